// File: rtl/warp_util_pkg.sv
// Shared helpers for the warp elastic-buffer family: occupancy classes and
// a clog2 used to size counters and pointers.
package warp_util_pkg;

   localparam logic [1:0] OCC_EMPTY   = 2'd0;
   localparam logic [1:0] OCC_PARTIAL = 2'd1;
   localparam logic [1:0] OCC_FULL    = 2'd2;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/warp_ring_ram.sv
// Register-array ring storage behind the output register: one write port,
// one asynchronous read port, no reset on the array.
module warp_ring_ram #(
   parameter int WIDTH   = 8,
   parameter int ENTRIES = 3,
   parameter int AW      = 2
) (
   input  logic             i_clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [ENTRIES];

   always_ff @(posedge i_clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/warp_skid_fifo.sv
// Ready/valid elastic buffer: registered head entry plus a DEPTH-1 slot ring.
// Optional synchronous flush port enabled by defining WARP_SKID_FIFO_FLUSH_EN.
module warp_skid_fifo
   import warp_util_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int CW    = clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 2) ? clog2(DEPTH - 1) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
`ifdef WARP_SKID_FIFO_FLUSH_EN
   input  logic             i_flush,
`endif
   input  logic             i_input_valid,
   output logic             o_input_ready,
   input  logic [WIDTH-1:0] i_input_data,
   output logic             o_output_valid,
   input  logic             i_output_ready,
   output logic [WIDTH-1:0] o_output_data,
   output logic [CW-1:0]    o_count
);

   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 2);

   logic [CW-1:0]    count;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [WIDTH-1:0] out_data;
   logic [WIDTH-1:0] ring_rdata;
   logic             insert;
   logic             remove;
   logic             bypass;
   logic             refill;
   logic             ring_we;
   logic             flush;

`ifdef WARP_SKID_FIFO_FLUSH_EN
   assign flush = i_flush;
`else
   assign flush = 1'b0;
`endif

   // Ready is a function of registered count only, never of i_output_ready.
   assign o_input_ready  = (count < CNT_FULL);
   assign o_output_valid = (count != '0);
   assign o_output_data  = out_data;
   assign o_count        = count;

   assign insert  = i_input_valid && o_input_ready;
   assign remove  = o_output_valid && i_output_ready;
   assign bypass  = insert && ((count == '0) || ((count == CW'(1)) && remove));
   assign refill  = remove && (count >= CW'(2));
   assign ring_we = insert && !bypass && !flush && i_rst_n;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         out_data <= '0;
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (bypass) begin
            out_data <= i_input_data;
         end else if (refill) begin
            out_data <= ring_rdata;
         end
         if (refill) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (ring_we) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (insert && !remove) begin
            count <= count + CW'(1);
         end else if (remove && !insert) begin
            count <= count - CW'(1);
         end
      end
   end

   warp_ring_ram #(
      .WIDTH   (WIDTH),
      .ENTRIES (DEPTH - 1),
      .AW      (PW)
   ) u_ring (
      .i_clk (i_clk),
      .we    (ring_we),
      .waddr (wr_ptr),
      .wdata (i_input_data),
      .raddr (rd_ptr),
      .rdata (ring_rdata)
   );

`ifdef FORMAL
   logic [1:0] occ_class;
   always_comb begin
      occ_class = OCC_PARTIAL;
      if (count == '0) occ_class = OCC_EMPTY;
      else if (count == CNT_FULL) occ_class = OCC_FULL;
   end
   cov_empty   : cover property (@(posedge i_clk) occ_class == OCC_EMPTY);
   cov_partial : cover property (@(posedge i_clk) occ_class == OCC_PARTIAL);
   cov_full    : cover property (@(posedge i_clk) occ_class == OCC_FULL);
`endif

endmodule

// File: tb/tb_warp_skid_fifo.sv
// Scoreboard bench for warp_skid_fifo: a queue-based reference model tracks
// accepted words and occupancy; a monitor compares every cycle.
module tb_warp_skid_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             out_ready;
   logic             flush;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    count;

   int               checks   = 0;
   int               failures = 0;
   logic [WIDTH-1:0] sbq [$];
   int               mcount   = 0;
   logic [WIDTH-1:0] last     = '0;
   bit               started  = 1'b0;

   always #5 clk = ~clk;

   warp_skid_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
`ifdef WARP_SKID_FIFO_FLUSH_EN
      .i_flush        (flush),
`endif
      .i_input_valid  (in_valid),
      .o_input_ready  (in_ready),
      .i_input_data   (in_data),
      .o_output_valid (out_valid),
      .i_output_ready (out_ready),
      .o_output_data  (out_data),
      .o_count        (count)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endfunction

   // Reference model updates on the edge; monitor compares mid-cycle.
   always begin
      bit ins;
      bit rem;
      @(posedge clk);
      if (!rst_n) begin
         mcount  = 0;
         sbq.delete();
         last    = '0;
         started = 1'b1;
      end else if (flush) begin
         if (mcount != 0 && sbq.size() != 0) last = sbq[0];
         mcount = 0;
         sbq.delete();
      end else begin
         ins = in_valid && (mcount < DEPTH);
         rem = out_ready && (mcount != 0);
         if (ins) sbq.push_back(in_data);
         mcount = mcount + int'(ins) - int'(rem);
      end

      @(negedge clk);
      if (started) begin
         chk("count", 32'(count), 32'(mcount));
         chk("in_ready", 32'(in_ready), 32'(mcount < DEPTH));
         chk("out_valid", 32'(out_valid), 32'(mcount != 0));
         chk("data_known", 32'($isunknown(out_data)), 32'd0);
         if (mcount != 0) begin
            if (sbq.size() == 0) begin
               chk("scoreboard_nonempty", 32'(sbq.size()), 32'd1);
            end else begin
               chk("head_data", 32'(out_data), 32'(sbq[0]));
               if (out_ready && rst_n && !flush) last = sbq.pop_front();
            end
         end else begin
            chk("held_data", 32'(out_data), 32'(last));
         end
      end
   end

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      drive(0, 8'h00, 0);

      // fill to full, then offer a word that must be refused
      drive(1, 8'h11, 0);
      drive(1, 8'h22, 0);
      drive(1, 8'h33, 0);
      drive(1, 8'h44, 0);
      drive(1, 8'h55, 0);
      drive(1, 8'h55, 0);
      for (int i = 0; i < 4; i++) drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);

      // streaming at one transfer per cycle
      for (int i = 0; i < 20; i++) drive(1, 8'(i), 1);
      drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);

      // random stalls, fill-biased then drain-biased
      for (int i = 0; i < 100; i++)
         drive(logic'($urandom_range(0, 3) != 0), 8'($urandom), logic'($urandom_range(0, 1)));
      for (int i = 0; i < 100; i++)
         drive(logic'($urandom_range(0, 1)), 8'($urandom), logic'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 6; i++) drive(0, 8'h00, 1);

      // reset with three entries held; handshakes in the reset cycle are ignored
      drive(1, 8'hA1, 0);
      drive(1, 8'hA2, 0);
      drive(1, 8'hA3, 0);
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hBB;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      drive(0, 8'h00, 0);
      drive(1, 8'h77, 1);
      drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);

`ifdef WARP_SKID_FIFO_FLUSH_EN
      drive(1, 8'hC1, 0);
      drive(1, 8'hC2, 0);
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_data   = 8'hEE;
      out_ready = 1'b1;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      drive(0, 8'h00, 1);
      drive(1, 8'h5A, 0);
      drive(0, 8'h00, 1);
      drive(0, 8'h00, 1);
`endif

      drive(0, 8'h00, 0);
      drive(0, 8'h00, 0);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
